return_stack: RTL

RETURN_STACK -- requirements
Module: return_stack

---
 rtl/return_stack.sv | 104 ++++++++++
 1 files changed

// File: rtl/return_stack.sv
// Hardware return-address stack for JSB/return. The top entry is read
// combinationally, so a return's next-PC select sees it in the pop cycle.
// Sticky overflow/underflow flags record dropped pushes and empty pops.
module return_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_stack,
  input  logic                       pop_stack,
  input  logic [AW-1:0]              push_data,
  input  logic                       err_clr,
  output logic [AW-1:0]              top_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] entry_q [DEPTH];
  logic [CW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] top_idx;
  logic          is_empty;
  logic          is_full;

  // Occupancy status and zero-latency top-of-stack read
  always_comb begin
    is_empty = (sp_q == '0);
    is_full  = (sp_q == FULL_CNT);
    // When full, the low PW bits of sp are zero and the decrement wraps to DEPTH-1
    top_idx  = sp_q[PW-1:0] - PW'(1);
    top_data = is_empty ? '0 : entry_q[top_idx];
    count    = sp_q;
    empty    = is_empty;
    full     = is_full;
    overflow  = ovf_q;
    underflow = unf_q;
  end

  // Next pointer, write port and sticky error flags for this cycle's request
  always_comb begin
    sp_d   = sp_q;
    wr_en  = 1'b0;
    wr_idx = sp_q[PW-1:0];
    ovf_d  = ovf_q;
    unf_d  = unf_q;

    if (push_stack && pop_stack && !is_empty) begin
      // Replace top: the return and the new call cancel in occupancy
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_stack) begin
      // A push paired with a pop on an empty stack behaves as a plain push
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + CW'(1);
      end
    end else if (pop_stack) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        sp_d = sp_q - CW'(1);
      end
    end

    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  // Pointer, flags and entry storage; reset clears everything asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (wr_en) begin
        entry_q[wr_idx] <= push_data;
      end
    end
  end

endmodule
